// File: rtl/line_mem_pkg.sv
// Shared definitions for the cache memory-side handshake: bus widths,
// responder states and the latched operation encoding.
package line_mem_pkg;

  localparam int LINE_W = 64;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/line_mem_array.sv
// Line storage: 2**INDEX_W x LINE_W, synchronous write, asynchronous read
// through a single shared line index.
module line_mem_array
  import line_mem_pkg::*;
#(
  parameter int INDEX_W = 14
) (
  input  logic               clk,
  input  logic               we,
  input  logic [INDEX_W-1:0] addr,
  input  logic [LINE_W-1:0]  wdata,
  output logic [LINE_W-1:0]  rdata
);

  logic [LINE_W-1:0] mem [2**INDEX_W];

  // NOTE: the array has no reset; clearing it would need a per-line reset
  // path that prevents RAM inference, and contents must survive reset anyway.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/line_memory.sv
// Backing-store responder for the readM/writeM/readyM line handshake.
// Define LINE_MEM_STATS_EN to add the num_read/num_write completion counters.
module line_memory
  import line_mem_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int INDEX_W = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              readM,
  input  logic              writeM,
  input  logic [ADDR_W-1:0] address,
  inout  wire  [LINE_W-1:0] data_mem,
  output logic              readyM
`ifdef LINE_MEM_STATS_EN
  ,
  output logic [15:0]       num_read,
  output logic [15:0]       num_write
`endif
);

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               ready_q, ready_d;

  logic               req_held;
  logic               mem_we;
  logic [LINE_W-1:0]  rd_data;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^address[1:0];

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b0;
    mem_we   = 1'b0;
    req_held = (op_q == OP_WR) ? writeM : readM;

    case (state_q)
      IDLE: begin
        if (writeM || readM) begin
          op_d    = writeM ? OP_WR : OP_RD;
          idx_d   = address[INDEX_W+1:2];
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // The initiator withdrawing its request cancels the transaction.
        if (!req_held) begin
          state_d = IDLE;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = RESP;
          ready_d = 1'b1;
        end
      end
      RESP: begin
        mem_we  = (op_q == OP_WR) && writeM;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      idx_q   <= '0;
      cnt_q   <= 8'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign readyM = ready_q;

  line_mem_array #(
    .INDEX_W (INDEX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (idx_q),
    .wdata (data_mem),
    .rdata (rd_data)
  );

  // The shared bus is only ours while a read response is on it.
  assign data_mem = (state_q == RESP && op_q == OP_RD) ? rd_data : {LINE_W{1'bz}};

`ifdef LINE_MEM_STATS_EN
  logic [15:0] num_read_q, num_read_d;
  logic [15:0] num_write_q, num_write_d;

  always_comb begin
    num_read_d  = num_read_q;
    num_write_d = num_write_q;
    if (state_q == RESP && op_q == OP_RD) num_read_d = num_read_q + 16'd1;
    if (mem_we) num_write_d = num_write_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_read_q  <= 16'd0;
      num_write_q <= 16'd0;
    end else begin
      num_read_q  <= num_read_d;
      num_write_q <= num_write_d;
    end
  end

  assign num_read  = num_read_q;
  assign num_write = num_write_q;
`endif

endmodule

// File: tb/tb_line_memory.sv
// Self-checking bench for line_memory: transaction-level model with a line
// dictionary, expected response cycle and per-cycle bus ownership checks.
module tb_line_memory;
  import line_mem_pkg::*;

  localparam int LAT = 4;
  localparam int IW  = 14;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        readM = 1'b0, writeM = 1'b0;
  logic [15:0] address = '0;
  wire  [63:0] data_mem;
  logic [63:0] bus_val = '0;
  logic        bus_en = 1'b1;
  logic        readyM;

  logic        readM2 = 1'b0, writeM2 = 1'b0;
  logic [15:0] address2 = 16'h0040;
  wire  [63:0] data_mem2;
  logic [63:0] bus2_val = '0;
  logic        bus2_en = 1'b1;
  logic        readyM2;

  assign data_mem  = bus_en  ? bus_val  : 64'hz;
  assign data_mem2 = bus2_en ? bus2_val : 64'hz;

`ifdef LINE_MEM_STATS_EN
  logic [15:0] num_read, num_write, num_read2, num_write2;
`endif

  line_memory #(.LATENCY(LAT), .INDEX_W(IW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .readM    (readM),
    .writeM   (writeM),
    .address  (address),
    .data_mem (data_mem),
    .readyM   (readyM)
`ifdef LINE_MEM_STATS_EN
    ,
    .num_read (num_read),
    .num_write(num_write)
`endif
  );

  line_memory #(.LATENCY(1), .INDEX_W(IW)) dut_l1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .readM    (readM2),
    .writeM   (writeM2),
    .address  (address2),
    .data_mem (data_mem2),
    .readyM   (readyM2)
`ifdef LINE_MEM_STATS_EN
    ,
    .num_read (num_read2),
    .num_write(num_write2)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] mem_model [int];
  int model_rd = 0;
  int model_wr = 0;

  function automatic int line_of(input logic [15:0] a);
    return int'(a >> 2) & ((1 << IW) - 1);
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // One complete transaction, starting at the beginning of a cycle (just
  // after a rising edge). abort_at>0 drops the request in that cycle.
  task automatic run_txn(input bit wr, input bit both, input logic [15:0] addr,
                         input logic [63:0] wdata, input int abort_at, input string name);
    int resp = LAT + 1;
    int last = (abort_at > 0) ? 10 : resp;
    int idx  = line_of(addr);
    bit hold;
    bit exp_rdy;
    for (int c = 0; c <= last; c++) begin
      hold    = (abort_at == 0) || (c < abort_at);
      writeM  = wr && hold;
      readM   = (!wr || both) && hold;
      address = (c == 0) ? addr : 16'($urandom());
      bus_en  = !(!wr && abort_at == 0 && c == resp);
      bus_val = (wr && c == resp) ? wdata : rnd64();
      @(negedge clk);
      exp_rdy = (abort_at == 0) && (c == resp);
      checks++;
      if (readyM !== exp_rdy) begin
        errors++;
        $display("FAIL %s readyM cycle %0d: got %b expected %b", name, c, readyM, exp_rdy);
      end
      checks++;
      if (bus_en) begin
        if (data_mem !== bus_val) begin
          errors++;
          $display("FAIL %s bus_not_released cycle %0d: got %h expected %h", name, c, data_mem, bus_val);
        end
      end else if (data_mem !== mem_model[idx]) begin
        errors++;
        $display("FAIL %s read_data: got %h expected %h", name, data_mem, mem_model[idx]);
      end
      @(posedge clk); #1;
    end
    readM  = 1'b0;
    writeM = 1'b0;
    bus_en = 1'b1;
    if (abort_at == 0) begin
      if (wr) begin
        mem_model[idx] = wdata;
        model_wr++;
      end else begin
        model_rd++;
      end
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_rd = 0;
    model_wr = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus_en  = 1'b1;
    bus_val = rnd64();
    @(negedge clk);
    checks++;
    if (readyM !== 1'b0) begin
      errors++;
      $display("FAIL reset readyM: got %b expected 0", readyM);
    end
    checks++;
    if (data_mem !== bus_val) begin
      errors++;
      $display("FAIL reset bus_released: got %h expected %h", data_mem, bus_val);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    run_txn(1'b1, 1'b0, 16'h0010, 64'hDEAD_BEEF_0123_4567, 0, "wr_0010");
    run_txn(1'b0, 1'b0, 16'h0013, 64'h0, 0, "rd_0013");
    checks++;
    if (mem_model[line_of(16'h0013)] !== 64'hDEAD_BEEF_0123_4567) begin
      errors++;
      $display("FAIL model_alias: got %h expected %h", mem_model[line_of(16'h0013)], 64'hDEAD_BEEF_0123_4567);
    end
  endtask

  task automatic test_abort();
    run_txn(1'b0, 1'b0, 16'h0010, 64'h0, 2, "abort_rd");
    run_txn(1'b1, 1'b0, 16'h0010, rnd64(), 0, "abort_follow_wr");
    run_txn(1'b0, 1'b0, 16'h0010, 64'h0, 0, "abort_follow_rd");
    run_txn(1'b1, 1'b0, 16'h0010, rnd64(), LAT, "abort_wr_late");
    run_txn(1'b0, 1'b0, 16'h0010, 64'h0, 0, "abort_wr_check");
  endtask

  task automatic test_priority();
    run_txn(1'b1, 1'b1, 16'h0020, 64'h1, 0, "prio_both");
    run_txn(1'b0, 1'b0, 16'h0020, 64'h0, 0, "prio_rd");
  endtask

  // Read request held high: one response every LAT+2 cycles.
  task automatic test_back_to_back();
    int idx = line_of(16'h0010);
    bit exp_rdy;
    for (int c = 0; c < 3 * (LAT + 2); c++) begin
      readM   = 1'b1;
      address = 16'h0010;
      exp_rdy = ((c + 1) % (LAT + 2)) == 0;
      bus_en  = !exp_rdy;
      bus_val = rnd64();
      @(negedge clk);
      checks++;
      if (readyM !== exp_rdy) begin
        errors++;
        $display("FAIL b2b readyM cycle %0d: got %b expected %b", c, readyM, exp_rdy);
      end
      if (exp_rdy) begin
        checks++;
        if (data_mem !== mem_model[idx]) begin
          errors++;
          $display("FAIL b2b read_data cycle %0d: got %h expected %h", c, data_mem, mem_model[idx]);
        end
        model_rd++;
      end
      @(posedge clk); #1;
    end
    readM  = 1'b0;
    bus_en = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] pool [6];
    logic [15:0] a;
    bit wr;
    for (int i = 0; i < 6; i++) begin
      pool[i] = 16'($urandom());
      run_txn(1'b1, 1'($urandom()), pool[i], rnd64(), 0, "rnd_fill");
    end
    for (int i = 0; i < 16; i++) begin
      a  = pool[$urandom_range(0, 5)];
      wr = 1'($urandom());
      if ($urandom_range(0, 3) == 0)
        run_txn(wr, 1'b0, a, rnd64(), int'($urandom_range(1, LAT)), "rnd_abort");
      else
        run_txn(wr, 1'($urandom()), a, rnd64(), 0, wr ? "rnd_wr" : "rnd_rd");
    end
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] old_v = rnd64();
    run_txn(1'b1, 1'b0, 16'h0030, old_v, 0, "rst_pre_wr");
    writeM  = 1'b1;
    address = 16'h0030;
    bus_en  = 1'b1;
    bus_val = ~old_v;
    repeat (3) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    checks++;
    if (readyM !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid readyM: got %b expected 0", readyM);
    end
    @(negedge clk);
    writeM = 1'b0;
    @(posedge clk); #1;
    reset_n  = 1'b1;
    model_rd = 0;
    model_wr = 0;
    run_txn(1'b0, 1'b0, 16'h0030, 64'h0, 0, "rst_post_rd");

    // Reset landing inside a read response must drop readyM and the bus at once.
    readM   = 1'b1;
    address = 16'h0030;
    for (int c = 0; c <= LAT; c++) begin @(posedge clk); #1; end
    bus_en = 1'b0;
    @(negedge clk);
    checks++;
    if (readyM !== 1'b1) begin
      errors++;
      $display("FAIL rst_resp pre readyM: got %b expected 1", readyM);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (readyM !== 1'b0) begin
      errors++;
      $display("FAIL rst_resp async readyM: got %b expected 0", readyM);
    end
    readM   = 1'b0;
    bus_en  = 1'b1;
    bus_val = rnd64();
    #1;
    checks++;
    if (data_mem !== bus_val) begin
      errors++;
      $display("FAIL rst_resp bus_released: got %h expected %h", data_mem, bus_val);
    end
    @(posedge clk); #1;
    reset_n  = 1'b1;
    model_rd = 0;
    model_wr = 0;
  endtask

  task automatic test_l1_back_to_back();
    logic [63:0] v = rnd64();
    bit exp_rdy;
    for (int c = 0; c < 3; c++) begin
      writeM2  = 1'b1;
      bus2_en  = 1'b1;
      bus2_val = v;
      @(negedge clk);
      checks++;
      if (readyM2 !== (c == 2)) begin
        errors++;
        $display("FAIL l1_wr readyM cycle %0d: got %b expected %b", c, readyM2, (c == 2));
      end
      @(posedge clk); #1;
    end
    writeM2 = 1'b0;
    for (int c = 0; c < 9; c++) begin
      readM2   = 1'b1;
      exp_rdy  = (c % 3) == 2;
      bus2_en  = !exp_rdy;
      bus2_val = rnd64();
      @(negedge clk);
      checks++;
      if (readyM2 !== exp_rdy) begin
        errors++;
        $display("FAIL l1_b2b readyM cycle %0d: got %b expected %b", c, readyM2, exp_rdy);
      end
      checks++;
      if (exp_rdy && data_mem2 !== v) begin
        errors++;
        $display("FAIL l1_b2b read_data cycle %0d: got %h expected %h", c, data_mem2, v);
      end else if (!exp_rdy && data_mem2 !== bus2_val) begin
        errors++;
        $display("FAIL l1_b2b bus_not_released cycle %0d: got %h expected %h", c, data_mem2, bus2_val);
      end
      @(posedge clk); #1;
    end
    readM2  = 1'b0;
    bus2_en = 1'b1;
`ifdef LINE_MEM_STATS_EN
    checks++;
    if (num_read2 !== 16'd3 || num_write2 !== 16'd1) begin
      errors++;
      $display("FAIL l1_stats: got rd=%0d wr=%0d expected rd=3 wr=1", num_read2, num_write2);
    end
`endif
  endtask

`ifdef LINE_MEM_STATS_EN
  task automatic check_stats(input string name);
    checks++;
    if (num_read !== 16'(model_rd) || num_write !== 16'(model_wr)) begin
      errors++;
      $display("FAIL %s: got rd=%0d wr=%0d expected rd=%0d wr=%0d",
               name, num_read, num_write, model_rd, model_wr);
    end
  endtask

  task automatic test_stats();
    pulse_reset();
    check_stats("stats_after_reset");
    run_txn(1'b1, 1'b0, 16'h0100, rnd64(), 0, "stats_wr");
    run_txn(1'b0, 1'b0, 16'h0100, 64'h0, 0, "stats_rd");
    run_txn(1'b0, 1'b0, 16'h0100, 64'h0, 3, "stats_abort_rd");
    run_txn(1'b1, 1'b1, 16'h0104, rnd64(), 0, "stats_wr");
    run_txn(1'b0, 1'b0, 16'h0104, 64'h0, 0, "stats_rd");
    run_txn(1'b0, 1'b0, 16'h0100, 64'h0, 0, "stats_rd");
    check_stats("stats_count");
    checks++;
    if (model_rd != 3 || model_wr != 2) begin
      errors++;
      $display("FAIL stats_model: got rd=%0d wr=%0d expected rd=3 wr=2", model_rd, model_wr);
    end
    pulse_reset();
    check_stats("stats_cleared");
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
`ifdef LINE_MEM_STATS_EN
    check_stats("stats_initial");
`endif
    test_write_read();
    test_abort();
    test_priority();
    test_back_to_back();
    test_random();
`ifdef LINE_MEM_STATS_EN
    check_stats("stats_running");
`endif
    test_reset_mid_op();
    test_l1_back_to_back();
`ifdef LINE_MEM_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_memory.md
Name: line_memory

Overview:
- Backing-store responder for the cache's memory-side handshake (readM / writeM / readyM).
- Holds 64-bit lines; the line index is taken from the word address.
- Serves one read or write-back per transaction after a fixed, parameterised latency.
- Sits between the cache and the top-level testbench or system wrapper, and drives the shared 64-bit bidirectional data bus only when returning read data.

Parameters:
- LATENCY, 4, wait cycles between request acceptance and the response cycle; legal range 1..255.
- INDEX_W, 14, line-index width; the index is address[INDEX_W+1:2] and the array depth is 2**INDEX_W lines.

Ports:
- clk  input  1  system clock, rising-edge active
- reset_n  input  1  asynchronous active-low reset
- readM  input  1  line read request, held by the initiator until readyM is seen
- writeM  input  1  line write request, held by the initiator until readyM is seen
- address  input  16  word address; bits [1:0] ignored
- data_mem  inout  64  line bus; this block drives it only during a read response, otherwise 'z
- readyM  output  1  single-cycle completion pulse

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=IDLE, readyM=0, cnt=0, latched op and index cleared, data_mem released to 'z.
  - Array contents are not cleared.
- FSM states: IDLE, BUSY, RESP. readyM is a registered output, 1 only in RESP.
- IDLE:
  - On a clk edge with writeM=1, accept a write; else with readM=1, accept a read. writeM has priority if both are high.
  - On accept: latch op and line index, load cnt=LATENCY-1, go to BUSY.
- BUSY:
  - If the latched request signal is low at an edge, abort: go to IDLE, no readyM, no write.
  - Else if cnt!=0, decrement cnt.
  - Else go to RESP.
- RESP (exactly one cycle):
  - readyM=1.
  - For a read, data_mem = array[latched index] for the whole cycle.
  - For a write, the edge ending RESP stores data_mem into array[latched index], but only if writeM is still 1.
  - Then go to IDLE unconditionally.
- Latency: if a request is first high in cycle N (sampled at the end of N), readyM is high in cycle N+LATENCY+1.
- The initiator drops its request on the edge that samples readyM, so IDLE normally sees it low. A request still high in IDLE is a new transaction (back-to-back allowed, with one IDLE cycle minimum between responses).
- Address changes after acceptance are ignored; the latched index is used.
- A read returns the value committed by any earlier write to the same line, including a write in the immediately preceding transaction.
- Reset mid-transaction: immediate return to IDLE, readyM drops asynchronously, any pending write is discarded.
- Bus contention rule: data_mem is driven by this block only when state==RESP and op==read.

Optional Feature:
- Macro: LINE_MEM_STATS_EN.
- When defined:
  - Extra outputs num_read[15:0] and num_write[15:0], reset to 0.
  - Each increments, wrapping at 16 bits, on the edge ending a completed RESP of its type.
  - Aborted transactions are not counted. A write RESP with writeM low is not counted.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package line_mem_pkg holds:
  - the state enum (IDLE, BUSY, RESP)
  - LINE_W=64
  - ADDR_W=16
  - the op encoding (OP_RD, OP_WR)
- The cache and this block share LINE_W and ADDR_W.
- One natural sub-module: line_mem_array, a synchronous-write, asynchronous-read 2**INDEX_W x 64 storage array with a write enable. The FSM, counter and tri-state driver stay in the top.

Test Plan (LATENCY=4 unless noted):
- Write then read: writeM with address=16'h0010, bus=64'hDEAD_BEEF_0123_4567, rising in cycle 10 -> readyM high only in cycle 15. Then readM, address=16'h0013 -> readyM high 5 cycles after request rise, data_mem=64'hDEAD_BEEF_0123_4567 during that cycle, 'z in all other cycles.
- Abort: readM rises in cycle 0, falls in cycle 2 -> no readyM in cycles 0..10. A following write to the same line completes normally.
- Priority: readM=writeM=1 to address 16'h0020 with bus=64'h1 -> write served (readyM with data_mem not driven by this block), a later read of 16'h0020 returns 64'h1.
- Reset mid-op: assert reset_n=0 in cycle 3 of a write to 16'h0030 -> readyM=0 immediately, state IDLE, a later read of 16'h0030 returns the previous contents.
- LATENCY=1 with back-to-back reads held high -> readyM every 3rd cycle (pattern 0,0,1,0,0,1).
- LINE_MEM_STATS_EN: 3 reads, 2 writes, 1 aborted read -> num_read=3, num_write=2. Reset -> both 0.
